// File: rtl/tlc5940_rx_model.sv
// Receive-side model of a TLC5940 LED driver: synchronizes the serial/PWM pins, shifts in
// 192-bit grayscale frames, latches them on XLAT and drives a 16-channel PWM comparator.
module tlc5940_rx_model #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sin_i,
  input  logic         sclk_i,
  input  logic         xlat_i,
  input  logic         blank_i,
  input  logic         gsclk_i,
  input  logic         vprg_i,
  input  logic         err_clr_i,
  output logic         sout_o,
  output logic [15:0]  out_on_o,
  output logic [191:0] gs_latched_o,
  output logic [11:0]  gs_count_o,
  output logic         gs_done_o,
  output logic [7:0]   bit_count_o,
  output logic         frame_err_o,
  output logic         xlat_blank_err_o
);

  // Pin vector order: {vprg, gsclk, blank, xlat, sclk, sin}; blank presets high.
  localparam logic [5:0] SyncRst = 6'b001000;

  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [2:0]                  dly_q;
  logic [5:0]                  pins;
  logic [5:0]                  pins_s;

  assign pins   = {vprg_i, gsclk_i, blank_i, xlat_i, sclk_i, sin_i};
  assign pins_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{SyncRst}};
      dly_q  <= 3'b000;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
      dly_q  <= {pins_s[4], pins_s[2], pins_s[1]};
    end
  end

  logic sin_s, blank_s, vprg_s;
  logic sclk_rise, xlat_rise, gsclk_rise;

  assign sin_s      = pins_s[0];
  assign blank_s    = pins_s[3];
  assign vprg_s     = pins_s[5];
  assign sclk_rise  = pins_s[1] & ~dly_q[0];
  assign xlat_rise  = pins_s[2] & ~dly_q[1];
  assign gsclk_rise = pins_s[4] & ~dly_q[2];

  logic [191:0] shift_q, shift_d;
  logic [191:0] gs_latched_q, gs_latched_d;
  logic [7:0]   bit_count_q, bit_count_d;
  logic [11:0]  gs_count_q, gs_count_d;
  logic         gs_done_q, gs_done_d;
  logic [15:0]  out_on_q, out_on_d;
  logic         sout_q, sout_d;
  logic         frame_err_q, frame_err_d;
  logic         xblank_err_q, xblank_err_d;
  logic         frame_set, xblank_set;

  always_comb begin
    shift_d      = shift_q;
    gs_latched_d = gs_latched_q;
    bit_count_d  = bit_count_q;
    gs_count_d   = gs_count_q;
    gs_done_d    = gs_done_q;
    out_on_d     = '0;
    frame_set    = 1'b0;
    xblank_set   = 1'b0;

    if (sclk_rise) begin
      shift_d = {shift_q[190:0], sin_s};
      if (bit_count_q != 8'hFF) bit_count_d = bit_count_q + 8'd1;
    end

    // Latch and frame check see pre-shift / pre-increment values on a coincident sclk edge.
    if (xlat_rise) begin
      bit_count_d = sclk_rise ? 8'd1 : 8'd0;
      if (!vprg_s) begin
        gs_latched_d = shift_q;
        frame_set    = (bit_count_q != 8'd192);
        xblank_set   = ~blank_s;
      end
    end

    frame_err_d  = frame_set | (frame_err_q & ~err_clr_i);
    xblank_err_d = xblank_set | (xblank_err_q & ~err_clr_i);

    if (blank_s) begin
      gs_count_d = 12'd0;
      gs_done_d  = 1'b0;
    end else if (gsclk_rise && !gs_done_q) begin
      if (gs_count_q == 12'hFFF) gs_done_d = 1'b1;
      else                       gs_count_d = gs_count_q + 12'd1;
    end

    for (int n = 0; n < 16; n++) begin
      out_on_d[n] = ~blank_s & ~gs_done_q & (gs_count_q < gs_latched_q[12*n +: 12]);
    end

    sout_d = shift_q[191];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      gs_latched_q <= '0;
      bit_count_q  <= '0;
      gs_count_q   <= '0;
      gs_done_q    <= 1'b0;
      out_on_q     <= '0;
      sout_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      xblank_err_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      gs_latched_q <= gs_latched_d;
      bit_count_q  <= bit_count_d;
      gs_count_q   <= gs_count_d;
      gs_done_q    <= gs_done_d;
      out_on_q     <= out_on_d;
      sout_q       <= sout_d;
      frame_err_q  <= frame_err_d;
      xblank_err_q <= xblank_err_d;
    end
  end

  assign sout_o           = sout_q;
  assign out_on_o         = out_on_q;
  assign gs_latched_o     = gs_latched_q;
  assign gs_count_o       = gs_count_q;
  assign gs_done_o        = gs_done_q;
  assign bit_count_o      = bit_count_q;
  assign frame_err_o      = frame_err_q;
  assign xlat_blank_err_o = xblank_err_q;

endmodule

// File: tb/tb_tlc5940_rx_model.sv
// Directed bench for tlc5940_rx_model: a pin-level model of the driver's frame/PWM
// behaviour is updated per pin action and compared against the DUT once outputs settle.
module tb_tlc5940_rx_model;

  logic clk = 1'b0;
  logic rst_n, sin, sclk, xlat, blank, gsclk, vprg, err_clr;
  logic         sout;
  logic [15:0]  out_on;
  logic [191:0] gs_latched;
  logic [11:0]  gs_count;
  logic         gs_done;
  logic [7:0]   bit_count;
  logic         frame_err, xlat_blank_err;

  always #5 clk = ~clk;

  tlc5940_rx_model #(.SYNC_STAGES(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sin_i            (sin),
    .sclk_i           (sclk),
    .xlat_i           (xlat),
    .blank_i          (blank),
    .gsclk_i          (gsclk),
    .vprg_i           (vprg),
    .err_clr_i        (err_clr),
    .sout_o           (sout),
    .out_on_o         (out_on),
    .gs_latched_o     (gs_latched),
    .gs_count_o       (gs_count),
    .gs_done_o        (gs_done),
    .bit_count_o      (bit_count),
    .frame_err_o      (frame_err),
    .xlat_blank_err_o (xlat_blank_err)
  );

  int checks = 0;
  int errors = 0;
  logic valid = 1'b0;

  // Model state: bits shifted since reset (newest last), per-channel GS words, PWM state.
  bit q_bits[$];
  int m_gs[16];
  int m_bits, m_count;
  bit m_done, m_ferr, m_xerr, m_blank, m_vprg;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [191:0] shift_vec();
    logic [191:0] v = '0;
    for (int i = 0; i < q_bits.size(); i++) v[i] = q_bits[q_bits.size()-1-i];
    return v;
  endfunction

  function automatic logic [191:0] exp_latched();
    logic [191:0] v = '0;
    for (int n = 0; n < 16; n++) v[12*n +: 12] = 12'(m_gs[n]);
    return v;
  endfunction

  function automatic logic [15:0] exp_out_on();
    logic [15:0] o = '0;
    for (int n = 0; n < 16; n++) o[n] = !m_blank && !m_done && (m_count < m_gs[n]);
    return o;
  endfunction

  function automatic logic exp_sout();
    return (q_bits.size() == 192) ? q_bits[0] : 1'b0;
  endfunction

  task automatic m_reset();
    q_bits.delete();
    for (int n = 0; n < 16; n++) m_gs[n] = 0;
    m_bits = 0; m_count = 0; m_done = 0; m_ferr = 0; m_xerr = 0;
  endtask

  task automatic m_shift(input bit b);
    q_bits.push_back(b);
    if (q_bits.size() > 192) void'(q_bits.pop_front());
    if (m_bits < 255) m_bits++;
  endtask

  task automatic m_latch();
    logic [191:0] v;
    if (!m_vprg) begin
      v = shift_vec();
      for (int n = 0; n < 16; n++) m_gs[n] = int'(v[12*n +: 12]);
      if (m_bits != 192) m_ferr = 1;
      if (!m_blank) m_xerr = 1;
    end
    m_bits = 0;
  endtask

  always @(negedge clk) begin
    if (valid) begin
      chk("out_on", {176'b0, out_on}, {176'b0, exp_out_on()});
      chk("gs_latched", gs_latched, exp_latched());
      chk("gs_count", {180'b0, gs_count}, 192'(m_count));
      chk("gs_done", {191'b0, gs_done}, {191'b0, m_done});
      chk("bit_count", {184'b0, bit_count}, 192'(m_bits));
      chk("sout", {191'b0, sout}, {191'b0, exp_sout()});
      chk("frame_err", {191'b0, frame_err}, {191'b0, m_ferr});
      chk("xlat_blank_err", {191'b0, xlat_blank_err}, {191'b0, m_xerr});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pin edges need 4 clk to reach out_on; 5 leaves margin.
  task automatic settle();
    valid = 1'b0;
    tick(5);
    valid = 1'b1;
  endtask

  task automatic sclk_bit(input bit b);
    sin = b; sclk = 1'b1; m_shift(b);
    settle(); tick(1);
    sclk = 1'b0; tick(2);
  endtask

  task automatic send_frame(input logic [191:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sclk_bit(v[i]);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) sclk_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic xlat_pulse();
    xlat = 1'b1; m_latch();
    settle(); tick(1);
    xlat = 1'b0; tick(2);
  endtask

  task automatic gsclk_pulse();
    gsclk = 1'b1;
    if (!m_blank && !m_done) begin
      if (m_count == 4095) m_done = 1;
      else m_count++;
    end
    settle(); tick(1);
    gsclk = 1'b0; tick(2);
  endtask

  task automatic set_blank(input bit v);
    blank = v; m_blank = v;
    if (v) begin m_count = 0; m_done = 0; end
    settle(); tick(1);
  endtask

  task automatic set_vprg(input bit v);
    vprg = v; m_vprg = v;
    settle(); tick(1);
  endtask

  task automatic clr_pulse();
    valid = 1'b0;
    err_clr = 1'b1; tick(1);
    err_clr = 1'b0; m_ferr = 0; m_xerr = 0;
    settle(); tick(1);
  endtask

  function automatic logic [191:0] rand_frame();
    logic [191:0] v;
    for (int n = 0; n < 16; n++) v[12*n +: 12] = 12'($urandom_range(0, 4095));
    return v;
  endfunction

  initial begin
    logic [191:0] v;
    rst_n = 1'b0; sin = 0; sclk = 0; xlat = 0; blank = 1; gsclk = 0; vprg = 0; err_clr = 0;
    m_blank = 1; m_vprg = 0; m_reset();

    // Reset held with blank low and gsclk running: outputs stay cleared.
    #1; valid = 1'b1; blank = 1'b0;
    for (int i = 0; i < 10; i++) begin gsclk = ~gsclk; tick(2); end
    chk("reset_out_on", {176'b0, out_on}, 192'd0);
    chk("reset_gs_count", {180'b0, gs_count}, 192'd0);
    gsclk = 1'b0; blank = 1'b1; tick(3);
    rst_n = 1'b1; settle(); tick(2);

    // Basic frame: channel 0 = 3.
    v = 192'h3;
    send_frame(v, 192);
    xlat_pulse();
    chk("basic_latched", gs_latched, 192'h3);
    chk("basic_frame_err", {191'b0, frame_err}, 192'd0);
    set_blank(0);
    chk("basic_on_cnt0", {176'b0, out_on}, 192'h1);
    for (int k = 1; k <= 5; k++) begin
      gsclk_pulse();
      chk("basic_on_ch0", {191'b0, out_on[0]}, (k < 3) ? 192'd1 : 192'd0);
    end
    chk("basic_on_others", {177'b0, out_on[15:1]}, 192'd0);
    set_blank(1);

    // Short frame of 191 bits.
    send_frame(rand_frame(), 191);
    xlat_pulse();
    chk("short_frame_err", {191'b0, frame_err}, 192'd1);
    clr_pulse();
    chk("short_frame_clr", {191'b0, frame_err}, 192'd0);

    // Full PWM cycle with all channels at 4095.
    send_frame({192{1'b1}}, 192);
    xlat_pulse();
    set_blank(0);
    for (int k = 1; k <= 4096; k++) begin
      gsclk_pulse();
      if (k == 4094) chk("pwm_on_4094", {176'b0, out_on}, 192'hFFFF);
      if (k == 4095) chk("pwm_off_4095", {176'b0, out_on}, 192'd0);
    end
    chk("pwm_done", {191'b0, gs_done}, 192'd1);
    chk("pwm_count_hold", {180'b0, gs_count}, 192'd4095);
    gsclk_pulse();
    chk("pwm_count_held", {180'b0, gs_count}, 192'd4095);
    set_blank(1);
    chk("pwm_blank_count", {180'b0, gs_count}, 192'd0);
    chk("pwm_blank_done", {191'b0, gs_done}, 192'd0);

    // XLAT with blank low, then XLAT in dot-correction mode.
    set_blank(0);
    xlat_pulse();
    chk("xblank_err", {191'b0, xlat_blank_err}, 192'd1);
    set_blank(1);
    clr_pulse();
    set_vprg(1);
    send_frame(rand_frame(), 192);
    xlat_pulse();
    chk("vprg_latched", gs_latched, {192{1'b1}});
    chk("vprg_no_err", {190'b0, frame_err, xlat_blank_err}, 192'd0);
    set_vprg(0);

    // Coincident sclk and xlat: latch pre-shift data, count becomes 1.
    send_frame(rand_frame(), 192);
    sin = 1'b1; sclk = 1'b1; xlat = 1'b1;
    m_latch(); m_shift(1'b1);
    settle(); tick(1);
    sclk = 1'b0; xlat = 1'b0; tick(2);
    chk("coinc_bit_count", {184'b0, bit_count}, 192'd1);
    chk("coinc_frame_err", {191'b0, frame_err}, 192'd0);

    // Error set in the same cycle as err_clr wins.
    valid = 1'b0;
    xlat = 1'b1;
    m_ferr = 0; m_xerr = 0; m_latch();
    tick(2); err_clr = 1'b1; tick(1); err_clr = 1'b0;
    settle(); tick(1);
    xlat = 1'b0; tick(2);
    chk("set_beats_clr", {191'b0, frame_err}, 192'd1);
    clr_pulse();

    // New latch mid-PWM-cycle.
    set_blank(0);
    for (int k = 0; k < 40; k++) gsclk_pulse();
    send_frame(rand_frame(), 192);
    xlat_pulse();
    for (int k = 0; k < 30; k++) gsclk_pulse();
    set_blank(1);
    clr_pulse();

    // bit_count saturation.
    send_rand(260);
    chk("bit_count_sat", {184'b0, bit_count}, 192'd255);
    xlat_pulse();
    clr_pulse();

    // Reset mid-shift discards partial data.
    send_rand(100);
    valid = 1'b0;
    rst_n = 1'b0; m_reset(); tick(2);
    rst_n = 1'b1; settle(); tick(1);
    chk("rst_bit_count", {184'b0, bit_count}, 192'd0);
    chk("rst_latched", gs_latched, 192'd0);
    send_frame(rand_frame(), 192);
    xlat_pulse();
    chk("rst_frame_ok", {191'b0, frame_err}, 192'd0);

    valid = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
